// File: rtl/address_button_conditioner_if.sv
// Button inputs and address-step outputs of the front-panel conditioner.
// The panel side uses master and the conditioner uses slave.
interface address_button_conditioner_if;
  logic inc_button;
  logic dec_button;
  logic increment_address;
  logic decrement_address;
  logic inc_pressed;
  logic dec_pressed;
  logic lockout;

  modport master (
    output inc_button, dec_button,
    input  increment_address, decrement_address, inc_pressed, dec_pressed, lockout
  );
  modport slave (
    input  inc_button, dec_button,
    output increment_address, decrement_address, inc_pressed, dec_pressed, lockout
  );
endinterface

// File: rtl/address_button_conditioner.sv
// Two identical button channels: a synchronizer, a debouncer and an auto-repeat FSM.
// A shared lockout silences both channels while both buttons are down.
module address_button_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES      = 8,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 40,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10,
  parameter bit          REPEAT_ENABLE        = 1'b1,
  parameter int unsigned COUNTER_WIDTH        = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic other_level,
  output logic level,
  output logic pulse,
  output logic locked
);
  localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] DB_LAST = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] RD_LAST = COUNTER_WIDTH'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] RP_LAST = COUNTER_WIDTH'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKED} state_t;

  logic [1:0]               sync;
  logic [COUNTER_WIDTH-1:0] dcnt, rcnt, rcnt_inc;
  state_t                   state;

  assign rcnt_inc = (&rcnt) ? rcnt : rcnt + ONE;
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[0], button};
  end

  // Any sample agreeing with the current level restarts the stability count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) begin
      dcnt <= '0;
    end else if (dcnt >= DB_LAST) begin
      level <= sync[1];
      dcnt  <= '0;
    end else begin
      dcnt <= dcnt + ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rcnt  <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      // Lockout wins over any pulse falling due on the same edge.
      if (level && other_level) begin
        if (state != LOCKED) begin
          state <= LOCKED;
          rcnt  <= '0;
        end
      end else begin
        unique case (state)
          IDLE: if (level) begin
            pulse <= 1'b1;
            state <= HOLD;
            rcnt  <= '0;
          end
          HOLD: if (!level) begin
            state <= IDLE;
            rcnt  <= '0;
          end else if (REPEAT_ENABLE && rcnt == RD_LAST) begin
            pulse <= 1'b1;
            state <= REPEAT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt_inc;
          end
          REPEAT: if (!level) begin
            state <= IDLE;
            rcnt  <= '0;
          end else if (rcnt == RP_LAST) begin
            pulse <= 1'b1;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt_inc;
          end
          LOCKED: if (!level) begin
            state <= IDLE;
            rcnt  <= '0;
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end
endmodule

module address_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES      = 8,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 40,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 10,
  parameter bit          REPEAT_ENABLE        = 1'b1,
  parameter int unsigned COUNTER_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  address_button_conditioner_if.slave  bus
);
  localparam int NUM_CH = 2;

  // Channel 0 is increment, channel 1 is decrement.
  logic [NUM_CH-1:0] button, level, pulse, locked;

  assign button = {bus.dec_button, bus.inc_button};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    address_button_conditioner_chan #(
      .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES),
      .REPEAT_ENABLE        (REPEAT_ENABLE),
      .COUNTER_WIDTH        (COUNTER_WIDTH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .button      (button[i]),
      .other_level (level[NUM_CH-1-i]),
      .level       (level[i]),
      .pulse       (pulse[i]),
      .locked      (locked[i])
    );
  end

  assign bus.increment_address = pulse[0];
  assign bus.decrement_address = pulse[1];
  assign bus.inc_pressed       = level[0];
  assign bus.dec_pressed       = level[1];
  assign bus.lockout           = |locked;
endmodule

// File: tb/tb_address_button_conditioner.sv
// Directed checks of press/release latency, bounce rejection, auto-repeat,
// lockout, asynchronous reset and the no-repeat variant.
module tb_address_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b1;

  address_button_conditioner_if bif ();
  address_button_conditioner_if bnr ();

  address_button_conditioner u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  address_button_conditioner #(.REPEAT_ENABLE(1'b0)) u_norep (
    .clk   (clk),
    .reset (reset),
    .bus   (bnr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int both_hi = 0;
  int inc_q[$], dec_q[$], nr_dec_q[$], nr_inc_q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // One active edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (bif.increment_address) inc_q.push_back(edge_n);
    if (bif.decrement_address) dec_q.push_back(edge_n);
    if (bnr.increment_address) nr_inc_q.push_back(edge_n);
    if (bnr.decrement_address) nr_dec_q.push_back(edge_n);
    if (bif.increment_address && bif.decrement_address) both_hi++;
  endtask

  task automatic clear_log();
    edge_n = 0;
    inc_q.delete(); dec_q.delete(); nr_inc_q.delete(); nr_dec_q.delete();
  endtask

  task automatic do_reset();
    bif.inc_button = 1'b0; bif.dec_button = 1'b0;
    bnr.inc_button = 1'b0; bnr.dec_button = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
  endtask

  initial begin
    int seen;
    bif.inc_button = 1'b0; bif.dec_button = 1'b0;
    bnr.inc_button = 1'b0; bnr.dec_button = 1'b0;

    // Clean single press with reset-state checks.
    do_reset();
    chk("rst_inc_addr", bif.increment_address, 0);
    chk("rst_dec_addr", bif.decrement_address, 0);
    chk("rst_pressed", {bif.inc_pressed, bif.dec_pressed}, 0);
    chk("rst_lockout", bif.lockout, 0);
    for (int k = 1; k <= 60; k++) begin
      bif.inc_button = (k <= 20);
      tick();
      if (k == 9)  chk("press_lvl_e9", bif.inc_pressed, 0);
      if (k == 10) chk("press_lvl_e10", bif.inc_pressed, 1);
      if (k == 29) chk("press_lvl_e29", bif.inc_pressed, 1);
      if (k == 31) chk("press_lvl_e31", bif.inc_pressed, 0);
    end
    chk("single_cnt", inc_q.size(), 1);
    chk("single_edge", qat(inc_q, 0), 11);
    chk("single_dec_cnt", dec_q.size(), 0);

    // Bounce rejection.
    do_reset();
    seen = 0;
    for (int k = 1; k <= 70; k++) begin
      bif.inc_button = (k <= 30) && (((k - 1) / 3) % 2 == 0);
      tick();
      if (bif.inc_pressed) seen++;
    end
    chk("bounce_pulses", inc_q.size(), 0);
    chk("bounce_level", seen, 0);

    // Auto-repeat.
    do_reset();
    for (int k = 1; k <= 120; k++) begin
      bif.inc_button = (k <= 80);
      tick();
    end
    chk("rep_cnt", inc_q.size(), 5);
    chk("rep_p0", qat(inc_q, 0), 11);
    chk("rep_p1", qat(inc_q, 1), 51);
    chk("rep_p2", qat(inc_q, 2), 61);
    chk("rep_p3", qat(inc_q, 3), 71);
    chk("rep_p4", qat(inc_q, 4), 81);

    // Lockout: both held, then dec released, then inc released and re-pressed.
    do_reset();
    for (int k = 1; k <= 110; k++) begin
      bif.inc_button = (k <= 70) || (k >= 91);
      bif.dec_button = (k >= 5) && (k <= 40);
      tick();
      if (k == 14) chk("lock_e14", bif.lockout, 0);
      if (k == 15) chk("lock_e15", bif.lockout, 1);
      if (k == 70) chk("lock_after_dec_rel", bif.lockout, 1);
      if (k == 70) chk("lock_inc_silent", inc_q.size(), 1);
      if (k == 90) chk("lock_cleared", bif.lockout, 0);
    end
    chk("lock_dec_cnt", dec_q.size(), 0);
    chk("lock_inc_cnt", inc_q.size(), 2);
    chk("lock_inc_p0", qat(inc_q, 0), 11);
    chk("lock_inc_p1", qat(inc_q, 1), 101);

    // Reset asserted while a repeat pulse is high.
    do_reset();
    bif.dec_button = 1'b1;
    for (int k = 1; k <= 61; k++) tick();
    chk("pre_rst_pulse", bif.decrement_address, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_dec", bif.decrement_address, 0);
    chk("async_rst_lvl", bif.dec_pressed, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_log();
    for (int k = 1; k <= 70; k++) tick();
    chk("rrst_p0", qat(dec_q, 0), 11);
    chk("rrst_p1", qat(dec_q, 1), 51);
    chk("rrst_p2", qat(dec_q, 2), 61);
    bif.dec_button = 1'b0;

    // REPEAT_ENABLE = 0: one pulse per press.
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      bnr.dec_button = 1'b1;
      tick();
    end
    chk("norep_cnt", nr_dec_q.size(), 1);
    chk("norep_edge", qat(nr_dec_q, 0), 11);
    chk("norep_inc_cnt", nr_inc_q.size(), 0);

    chk("never_both", both_hi, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
